// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and parameter defaults for the SPI byte sequencer.
package spi_pkg;
    localparam int DEPTH_DEF = 8;
    localparam int TMO_DEF   = 1024;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        CAPTURE   = 2'd3
    } state_e;
endpackage

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: DEPTH-entry byte FIFO with extra-MSB wrap pointers, no fall-through.
//   clk, rst          clock, asynchronous active-high reset
//   wr_data, wr_en    push side; push is refused while full
//   full              no room for another byte
//   rd_data, rd_en    pop side; rd_data is the head, forced to 0 while empty
//   empty             no byte stored
module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic [7:0] rd_data,
    input  logic       rd_en,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic        push, pop;
    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        push    = wr_en && !full;
        pop     = rd_en && !empty;
        wr_d    = wr_q + (AW+1)'(push);
        rd_d    = rd_q + (AW+1)'(pop);
        rd_data = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: feeds host bytes one at a time to an SPI master and buffers the replies.
//   clk, rst                    clock, asynchronous active-high reset
//   tx_data/tx_valid/tx_ready   host -> TX FIFO byte stream
//   rx_data/rx_valid/rx_ready   RX FIFO -> host byte stream
//   spi_data/spi_en             byte and transfer request to the SPI master
//   spi_busy/spi_rdata          master busy (unsynchronized) and received byte
//   active                      FSM not in IDLE
//   err_tmo/err_ovf/clr_err     sticky launch-timeout / RX-overflow flags and their clear
module spi_byte_sequencer
    import spi_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] spi_data,
    output logic       spi_en,
    input  logic       spi_busy,
    input  logic [7:0] spi_rdata,
    output logic       active,
    output logic       err_tmo,
    output logic       err_ovf,
    input  logic       clr_err
);
    localparam int CW = $clog2(TMO) + 1;
    state_e        state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [7:0]    spi_data_q, spi_data_d, tx_head;
    logic          err_tmo_q, err_tmo_d, err_ovf_q, err_ovf_d;
    logic          busy_m_q, busy_s_q, rst_m_q, rst_s_q;
    logic          tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push, tmo_set, ovf_set;

    spi_byte_fifo #(.DEPTH(DEPTH)) u_tx (
        .clk(clk), .rst(rst), .wr_data(tx_data), .wr_en(tx_valid), .full(tx_full),
        .rd_data(tx_head), .rd_en(tx_pop), .empty(tx_empty)
    );
    spi_byte_fifo #(.DEPTH(DEPTH)) u_rx (
        .clk(clk), .rst(rst), .wr_data(spi_rdata), .wr_en(rx_push), .full(rx_full),
        .rd_data(rx_data), .rd_en(rx_ready), .empty(rx_empty)
    );

    // rst_s_q keeps the FSM parked in IDLE for two clocks after rst is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_m_q <= 1'b0;
            busy_s_q <= 1'b0;
            rst_m_q  <= 1'b1;
            rst_s_q  <= 1'b1;
        end else begin
            busy_m_q <= spi_busy;
            busy_s_q <= busy_m_q;
            rst_m_q  <= 1'b0;
            rst_s_q  <= rst_m_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        spi_data_d = spi_data_q;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        tmo_set    = 1'b0;
        ovf_set    = 1'b0;
        if (!rst_s_q) begin
            case (state_q)
                IDLE: if (!tx_empty && !busy_s_q) begin
                    state_d    = LAUNCH;
                    tx_pop     = 1'b1;
                    spi_data_d = tx_head;
                    tmo_d      = '0;
                end
                LAUNCH: if (busy_s_q) state_d = WAIT_DONE;
                    else if (tmo_q == CW'(TMO - 1)) begin
                        state_d = IDLE;
                        tmo_set = 1'b1;
                    end else tmo_d = tmo_q + 1'b1;
                WAIT_DONE: if (!busy_s_q) state_d = CAPTURE;
                CAPTURE: begin
                    state_d = IDLE;
                    rx_push = !rx_full;
                    ovf_set = rx_full;
                end
                default: state_d = IDLE;
            endcase
        end
        // A set event in the same cycle as clr_err wins.
        err_tmo_d = tmo_set || (err_tmo_q && !clr_err);
        err_ovf_d = ovf_set || (err_ovf_q && !clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            spi_data_q <= 8'h00;
            err_tmo_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            spi_data_q <= spi_data_d;
            err_tmo_q  <= err_tmo_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign spi_data = spi_data_q;
    assign spi_en   = state_q == LAUNCH;
    assign active   = state_q != IDLE;
    assign err_tmo  = err_tmo_q;
    assign err_ovf  = err_ovf_q;
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// tb_spi_byte_sequencer: self-checking bench with a loopback SPI master model and a byte scoreboard.
module tb_spi_byte_sequencer;
    localparam int M_NORM = 0, M_HOLD = 1, M_DEAD = 2;

    logic       clk = 0, rst = 1;
    logic [7:0] tx_data = 0, rx_data, spi_data, spi_rdata;
    logic       tx_valid = 0, tx_ready, rx_valid, rx_ready = 0, spi_en, spi_busy;
    logic       active, err_tmo, err_ovf, clr_err = 0;

    int         passed = 0, total = 0, mode = M_NORM, en_pulses = 0, viol = 0;
    logic       en_prev = 0;
    logic [7:0] data_prev = 0, mosi = 0;
    logic [7:0] model[$];

    typedef struct { logic [7:0] data; int gap; logic [7:0] exp; } vec_t;
    vec_t vecs[6];

    spi_byte_sequencer #(.DEPTH(8), .TMO(16)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .spi_data(spi_data),
        .spi_en(spi_en), .spi_busy(spi_busy), .spi_rdata(spi_rdata), .active(active),
        .err_tmo(err_tmo), .err_ovf(err_ovf), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Loopback master: answers a request with a 2..6 cycle busy pulse and returns mosi as miso.
    initial begin
        spi_busy = 0;
        spi_rdata = 0;
        forever begin
            @(negedge clk);
            if (mode == M_HOLD) spi_busy = 1;
            else if (mode == M_DEAD || spi_busy) spi_busy = 0;
            else if (spi_en) begin
                mosi = spi_data;
                spi_busy = 1;
                repeat ($urandom_range(2, 6)) @(negedge clk);
                spi_rdata = mosi;
                spi_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (spi_en && !en_prev) en_pulses++;
        if (spi_en && en_prev && spi_data != data_prev) viol++;
        en_prev = spi_en;
        data_prev = spi_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk("push_timeout", 0, 1);
        tx_data = b;
        tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
    endtask

    task automatic wait_rx();
        int n = 0;
        while (!rx_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop_expect(input string name, input int exp);
        wait_rx();
        if (!rx_valid) chk({name, "_timeout"}, -1, exp);
        else begin
            chk(name, rx_data, exp);
            rx_ready = 1;
            @(negedge clk);
            rx_ready = 0;
        end
    endtask

    initial begin
        int n, p0;
        logic e16;
        vecs[0] = '{8'hA5, 0, 8'hA5};
        vecs[1] = '{8'h00, 3, 8'h00};
        vecs[2] = '{8'hFF, 1, 8'hFF};
        vecs[3] = '{8'h5A, 0, 8'h5A};
        vecs[4] = '{8'h81, 5, 8'h81};
        vecs[5] = '{8'h3C, 2, 8'h3C};

        #1;
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_active", active, 0);
        chk("rst_spi_en", spi_en, 0);
        chk("rst_spi_data", spi_data, 0);
        chk("rst_errs", {err_tmo, err_ovf}, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            p0 = en_pulses;
            push(vecs[i].data);
            repeat (vecs[i].gap) @(negedge clk);
            pop_expect("vec_rx_data", vecs[i].exp);
            chk("vec_en_pulse", en_pulses - p0, 1);
            chk("vec_errs", {err_tmo, err_ovf}, 0);
        end

        mode = M_HOLD;
        repeat (4) @(negedge clk);
        p0 = en_pulses;
        for (int i = 0; i < 8; i++) begin
            push(8'hC0 + 8'(i));
            model.push_back(8'hC0 + 8'(i));
        end
        chk("full_tx_ready", tx_ready, 0);
        tx_data = 8'hEE;
        tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
        chk("full_refused", tx_ready, 0);
        chk("full_held_idle", active, 0);
        mode = M_NORM;
        for (int i = 0; i < 8; i++) pop_expect("full_order", model.pop_front());
        repeat (40) @(negedge clk);
        chk("full_no_ninth", rx_valid, 0);
        chk("full_pulses", en_pulses - p0, 8);

        mode = M_DEAD;
        clr_err = 1;
        push(8'h77);
        n = 0;
        while (!spi_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        e16 = 1;
        while (spi_en && n < 100) begin
            n++;
            if (n == 16) e16 = err_tmo;
            @(negedge clk);
        end
        chk("tmo_launch_cycles", n, 16);
        chk("tmo_err_before", e16, 0);
        chk("tmo_set_wins_clr", err_tmo, 1);
        chk("tmo_back_idle", active, 0);
        clr_err = 0;
        @(negedge clk);
        chk("tmo_sticky", err_tmo, 1);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        chk("tmo_cleared", err_tmo, 0);
        mode = M_NORM;
        push(8'h3C);
        pop_expect("tmo_next_byte", 8'h3C);
        chk("tmo_dropped", rx_valid, 0);

        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
        n = 0;
        while (!err_ovf && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_idle", active, 0);
        for (int i = 0; i < 8; i++) pop_expect("ovf_data", 8'h10 + 8'(i));
        chk("ovf_ninth_lost", rx_valid, 0);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        chk("ovf_cleared", err_ovf, 0);

        fork
            for (int i = 0; i < 30; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push(b);
                model.push_back(b);
            end
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                wait_rx();
                pop_expect("rand_data", model.size() ? int'(model.pop_front()) : -1);
            end
        join
        chk("rand_errs", {err_tmo, err_ovf}, 0);

        push(8'h99);
        push(8'h98);
        n = 0;
        while (!spi_en && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (spi_en && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("rstw_in_wait", active, 1);
        rst = 1;
        #1;
        p0 = en_pulses;
        chk("rstw_spi_en", spi_en, 0);
        chk("rstw_rx_valid", rx_valid, 0);
        chk("rstw_active", active, 0);
        chk("rstw_tx_ready", tx_ready, 1);
        @(negedge clk);
        rst = 0;
        repeat (40) @(negedge clk);
        chk("rstw_no_relaunch", en_pulses - p0, 0);
        chk("rstw_no_capture", rx_valid, 0);

        chk("spi_data_stable", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spi_byte_sequencer.md
SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, TX and RX FIFO depth in bytes; power of two, 2..64.
REQ-002 Parameter TMO, default 1024, clk cycles allowed for spi_busy to rise after launch.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port tx_data  input  8  byte for the host to transmit.
REQ-006 Port tx_valid  input  1  tx_data valid; a byte is accepted when tx_valid and tx_ready are both high on a clk edge.
REQ-007 Port tx_ready  output  1  TX FIFO not full.
REQ-008 Port rx_data  output  8  head of the RX FIFO.
REQ-009 Port rx_valid  output  1  RX FIFO not empty.
REQ-010 Port rx_ready  input  1  host pops rx_data when rx_valid and rx_ready are both high.
REQ-011 Port spi_data  output  8  byte presented to the SPI master data input.
REQ-012 Port spi_en  output  1  transfer request to the SPI master.
REQ-013 Port spi_busy  input  1  SPI master busy, asynchronous to clk's sck domain.
REQ-014 Port spi_rdata  input  8  byte received by the SPI master.
REQ-015 Port active  output  1  high in any state other than IDLE.
REQ-016 Port err_tmo  output  1  sticky timeout flag.
REQ-017 Port err_ovf  output  1  sticky flag: received byte dropped because the RX FIFO was full.
REQ-018 Port clr_err  input  1  clears err_tmo and err_ovf; a set event in the same cycle wins.

Function
REQ-019 spi_busy SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value, busy_s.
REQ-020 FSM states: IDLE, LAUNCH, WAIT_DONE, CAPTURE.
REQ-021 IDLE -> LAUNCH when the TX FIFO is non-empty and busy_s is low; on this edge, pop the TX head into spi_data.
REQ-022 In LAUNCH, spi_en SHALL be high and spi_data stable; -> WAIT_DONE on the first cycle busy_s is high.
REQ-023 If busy_s stays low for TMO cycles in LAUNCH: set err_tmo, drop the byte, deassert spi_en, and go to IDLE.
REQ-024 In WAIT_DONE, spi_en SHALL be low; -> CAPTURE on the first cycle busy_s is low (falling edge).
REQ-025 In CAPTURE, push spi_rdata into the RX FIFO, then go to IDLE; if the RX FIFO is full, do not push and set err_ovf instead.
REQ-026 spi_en SHALL be high only in LAUNCH; spi_data SHALL hold its value outside LAUNCH.
REQ-027 Each FIFO SHALL use log2(DEPTH)+1-bit pointers; full when the MSBs differ and the low bits are equal; pointers wrap modulo 2*DEPTH.
REQ-028 Simultaneous push and pop on a full FIFO: the pop succeeds and the push is refused (tx_ready is low).
REQ-029 Simultaneous push and pop on a non-full, non-empty FIFO: both succeed and the count is unchanged.
REQ-030 Push on an empty FIFO: rx_valid/tx-side non-empty SHALL rise the next cycle; there is no fall-through.
REQ-031 Throughput: one byte per SPI transfer, plus at most 4 clk of overhead per byte.

Reset
REQ-032 On rst high, immediately and asynchronously: FSM -> IDLE; both FIFOs empty; spi_en=0; spi_data=0; err_tmo=0; err_ovf=0; synchronizer flops=0.
REQ-033 Reset values of the derived outputs: tx_ready=1, rx_valid=0, rx_data=0, active=0.
REQ-034 Reset during LAUNCH or WAIT_DONE SHALL abandon the transfer; no RX push occurs.
REQ-035 Release of rst SHALL be synchronized to clk (two-flop synchronizer) before it reaches the FSM.

Structure
REQ-036 Shared package spi_pkg SHALL hold the FSM state encoding (2 bits) and the defaults for DEPTH and TMO.
REQ-037 One sub-module, spi_byte_fifo (parameterized by DEPTH, 8-bit data), SHALL be instantiated twice, once for TX and once for RX.
REQ-038 The timeout counter SHALL be $clog2(TMO)+1 bits wide and SHALL be cleared on every entry to LAUNCH.

Verification
REQ-039 Push 0xA5 with a behavioural master model that loops mosi back to miso -> spi_en pulse seen, rx_data=0xA5, rx_valid=1, err flags 0.
REQ-040 Push 8 bytes with DEPTH=8 while busy_s is held high -> tx_ready=0 after the 8th push; the 9th push is refused; all 8 bytes are then transmitted in order.
REQ-041 Tie spi_busy=0 with TMO=16 -> err_tmo=1 on the 16th LAUNCH cycle; FSM returns to IDLE; the next byte is launched afterwards.
REQ-042 With rx_ready=0, run 9 transfers at DEPTH=8 -> 8 bytes buffered, err_ovf=1, the 9th byte is lost, and the first 8 bytes read out intact.
REQ-043 Assert rst in WAIT_DONE -> spi_en=0, FIFOs empty, rx_valid=0 in the same cycle; no spurious capture occurs after release.
REQ-044 Hold clr_err high in the same cycle as a timeout event -> err_tmo reads 1.
